serial_adder: RTL

- Bit-serial adder built around a single full-adder cell with a registered carry loop. The carry-out of each bit is fed back as the carry-in of the next bit.
- Accepts two WIDTH-bit operands plus carry-in on a start pulse, processes one bit per clock LSB-first, and presents the registered sum and carry-out with a done pulse.
- Area-cheap alternative to the ripple-carry adder in the same arithmetic library. Its result must be bit-identical to the ripple-carry adder's.

---
 rtl/serial_adder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell with a registered carry loop, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             fa_sum, fa_cout;
  logic [WIDTH-1:0] sum_next;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    c_d      = c_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif
    fa_sum   = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    fa_cout  = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
    // New bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0.
    sum_next = WIDTH'({fa_sum, sum_sh_q} >> 1);

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_next;
        c_d      = fa_cout;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          sum_d   = sum_next;
          cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
          // c_q is the carry into the MSB on the last bit.
          ovf_d   = c_q ^ fa_cout;
`endif
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      c_q      <= c_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
